// File: rtl/apb_pwm_sequencer_if.sv
// APB bus between the PWM sequencer (master)
// and the shared APB PWM slave.
interface apb_pwm_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic                  PREADY;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );
endinterface

// File: rtl/apb_pwm_sequencer.sv
// Round-robin APB master sharing one PWM slave:
// disable, load profile, enable, read back.
module apb_pwm_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 1024,
  localparam int IW = $clog2(NUM_REQ) + 1,
  localparam int TW = $clog2(TIMEOUT) + 1,
  localparam int DW = DATA_WIDTH
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*DW-1:0] req_duty,
  input  logic [NUM_REQ*DW-1:0] req_period,
  input  logic [NUM_REQ*DW-1:0] req_length,
  output logic                  done_valid,
  output logic [IW-1:0]         done_id,
  output logic                  done_err,
  output logic                  busy,
  apb_pwm_sequencer_if.master   apb
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ACCESS, READ_WAIT, CHECK, DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [2:0]    step;
  logic [2:0]    nstep;
  logic [TW-1:0] tcnt;
  logic [DW-1:0] duty_q;
  logic [DW-1:0] period_q;
  logic [DW-1:0] length_q;

  logic [IW-1:0] gnt;
  logic          gnt_any;
  int            idx;
  int            gi;
  logic [DW-1:0] g_duty;
  logic [DW-1:0] g_period;
  logic [DW-1:0] g_length;
  logic [DW-1:0] naddr;
  logic [DW-1:0] ndata;
  logic          tmo;

  // Scan downwards so the nearest index after ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        gnt     = IW'(idx);
        gnt_any = 1'b1;
      end
    end
  end

  always_comb begin
    gi       = int'(gnt);
    g_duty   = req_duty[gi*DW +: DW];
    g_period = req_period[gi*DW +: DW];
    g_length = req_length[gi*DW +: DW];
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_any)
      req_ready = NUM_REQ'(1) << gnt;
  end

  assign busy  = (state != IDLE);
  assign nstep = step + 3'd1;
  assign tmo   = (tcnt == TW'(TIMEOUT - 1));

  always_comb begin
    naddr = DW'(8);
    ndata = '0;
    unique case (1'b1)
      (nstep == 3'd1): begin
        naddr = DW'(0);
        ndata = duty_q;
      end
      (nstep == 3'd2): begin
        naddr = DW'(4);
        ndata = period_q;
      end
      (nstep == 3'd3): begin
        naddr = DW'(12);
        ndata = length_q;
      end
      (nstep == 3'd4): begin
        naddr = DW'(8);
        ndata = DW'(1);
      end
      default: begin
        naddr = DW'(8);
        ndata = '0;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      ptr         <= IW'(NUM_REQ - 1);
      step        <= '0;
      tcnt        <= '0;
      duty_q      <= '0;
      period_q    <= '0;
      length_q    <= '0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      done_valid  <= 1'b0;
      done_id     <= '0;
      done_err    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            ptr      <= gnt;
            step     <= '0;
            duty_q   <= (g_duty > DW'(100)) ? DW'(100) : g_duty;
            period_q <= g_period;
            length_q <= g_length;
            if (g_period == '0) begin
              state      <= DONE;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
              done_id    <= gnt;
            end else begin
              state      <= SETUP;
              apb.PSEL   <= 1'b1;
              apb.PWRITE <= 1'b1;
              apb.PADDR  <= DW'(8);
              apb.PWDATA <= '0;
            end
          end
        end
        SETUP: begin
          state       <= ACCESS;
          apb.PENABLE <= 1'b1;
          tcnt        <= '0;
        end
        ACCESS: begin
          if (apb.PREADY && !apb.PSLVERR && step != 3'd5) begin
            state       <= SETUP;
            step        <= nstep;
            apb.PENABLE <= 1'b0;
            apb.PADDR   <= naddr;
            apb.PWDATA  <= ndata;
            apb.PWRITE  <= (nstep != 3'd5);
          end else if (apb.PREADY || tmo) begin
            // Normal read completion, slave error or timeout
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PADDR   <= '0;
            apb.PWDATA  <= '0;
            if (apb.PREADY && !apb.PSLVERR) begin
              state <= READ_WAIT;
            end else begin
              state      <= DONE;
              done_valid <= 1'b1;
              done_err   <= 1'b1;
              done_id    <= ptr;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        READ_WAIT: state <= CHECK;
        CHECK: begin
          state      <= DONE;
          done_valid <= 1'b1;
          done_err   <= ~apb.PRDATA[0];
          done_id    <= ptr;
        end
        DONE: begin
          state      <= IDLE;
          done_valid <= 1'b0;
          done_err   <= 1'b0;
          done_id    <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
